// File: rtl/delay_sched.sv
// delay_sched: shares one external delayx delay line (N bits, DELAY stages) among R requesters.
// A round-robin arbiter grants one sample per advancing cycle and drives the line's d/ce; a
// valid/tag pipeline running in lockstep with the line records which requester owns each slot.
// The sample leaves DELAY advancing cycles later on a valid/ready port. Backpressure stalls the
// whole line through dl_ce_o.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i[R], din_i[R*N]   per-requester request and sample (requester i on din_i[i*N +: N])
//   gnt_o[R]               one-hot grant; sample taken on the edge where req_i[i] & gnt_o[i]
//   dl_ce_o, dl_d_o        drive the delayx ce / d
//   dl_q_i                 delayx q
//   q_valid_o, q_tag_o,    output sample, owning requester and data (q_data_o == dl_q_i)
//   q_data_o, q_ready_i
//
// Optional: define DELAY_SCHED_STATS_EN to add stat_clr_i, stat_grants_o and stat_stalls_o
// (saturating counts of granted edges and stalled edges).
module delay_sched #(
  parameter int unsigned N     = 16,
  parameter int unsigned DELAY = 4,
  parameter int unsigned R     = 4,
  parameter int unsigned TW    = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [R-1:0]   req_i,
  input  logic [R*N-1:0] din_i,
  output logic [R-1:0]   gnt_o,
  output logic           dl_ce_o,
  output logic [N-1:0]   dl_d_o,
  input  logic [N-1:0]   dl_q_i,
  output logic           q_valid_o,
  output logic [TW-1:0]  q_tag_o,
  output logic [N-1:0]   q_data_o,
  input  logic           q_ready_i
`ifdef DELAY_SCHED_STATS_EN
  ,
  input  logic           stat_clr_i,
  output logic [31:0]    stat_grants_o,
  output logic [31:0]    stat_stalls_o
`endif
);

  logic [TW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DELAY-1:0] vpipe_q, vpipe_d;
  logic [TW-1:0]    tpipe_q [DELAY];
  logic [TW-1:0]    tpipe_d [DELAY];
  logic             adv;
  logic             any_gnt;
  logic [TW-1:0]    gnt_idx;

  // Only a valid sample that is refused holds the line; a bubble at the output always advances.
  assign adv       = ~(q_valid_o & ~q_ready_i);
  assign dl_ce_o   = adv;
  assign q_valid_o = vpipe_q[DELAY-1];
  assign q_tag_o   = tpipe_q[DELAY-1];
  assign q_data_o  = dl_q_i;

  // Round-robin scan from rr_ptr_q upward, then wrap to the indices below it.
  always_comb begin
    gnt_o   = '0;
    any_gnt = 1'b0;
    gnt_idx = '0;
    dl_d_o  = '0;
    if (adv) begin
      for (int unsigned i = 0; i < R; i++) begin
        if (!any_gnt && req_i[i] && (i >= 32'(rr_ptr_q))) begin
          any_gnt  = 1'b1;
          gnt_idx  = TW'(i);
          gnt_o[i] = 1'b1;
          dl_d_o   = din_i[i*N +: N];
        end
      end
      for (int unsigned i = 0; i < R; i++) begin
        if (!any_gnt && req_i[i] && (i < 32'(rr_ptr_q))) begin
          any_gnt  = 1'b1;
          gnt_idx  = TW'(i);
          gnt_o[i] = 1'b1;
          dl_d_o   = din_i[i*N +: N];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_gnt) begin
      rr_ptr_d = (gnt_idx == TW'(R - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Slot k tracks delayx stage k, so the valid/tag pipe shifts exactly when the line does.
  always_comb begin
    vpipe_d = vpipe_q;
    tpipe_d = tpipe_q;
    if (adv) begin
      vpipe_d[0] = any_gnt;
      tpipe_d[0] = gnt_idx;
      for (int unsigned k = 1; k < DELAY; k++) begin
        vpipe_d[k] = vpipe_q[k-1];
        tpipe_d[k] = tpipe_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      vpipe_q  <= '0;
      for (int unsigned k = 0; k < DELAY; k++) begin
        tpipe_q[k] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vpipe_q  <= vpipe_d;
      for (int unsigned k = 0; k < DELAY; k++) begin
        tpipe_q[k] <= tpipe_d[k];
      end
    end
  end

`ifdef DELAY_SCHED_STATS_EN
  logic [31:0] grants_q, grants_d;
  logic [31:0] stalls_q, stalls_d;

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    grants_d = grants_q;
    stalls_d = stalls_q;
    if (stat_clr_i) begin
      grants_d = '0;
      stalls_d = '0;
    end else begin
      if (any_gnt && (grants_q != '1)) grants_d = grants_q + 32'd1;
      if (!adv && (stalls_q != '1))    stalls_d = stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      grants_q <= grants_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_grants_o = grants_q;
  assign stat_stalls_o = stalls_q;
`endif

endmodule

// File: tb/tb_delay_sched.sv
// Bench for delay_sched (N=16, DELAY=4, R=4, TW=2) with a behavioural delayx line.
// Stimulus steps carry hand-derived grants; each expected output is queued at grant time and
// a separate monitor pops and compares whenever the DUT hands over a sample.
module tb_delay_sched;
  localparam int unsigned N     = 16;
  localparam int unsigned DELAY = 4;
  localparam int unsigned R     = 4;
  localparam int unsigned TW    = 2;

  logic           clk;
  logic           rst_n;
  logic [R-1:0]   req;
  logic [R*N-1:0] din;
  logic [R-1:0]   gnt;
  logic           dl_ce;
  logic [N-1:0]   dl_d;
  logic [N-1:0]   dl_q;
  logic           q_valid;
  logic [TW-1:0]  q_tag;
  logic [N-1:0]   q_data;
  logic           q_ready;
`ifdef DELAY_SCHED_STATS_EN
  logic           stat_clr;
  logic [31:0]    stat_grants;
  logic [31:0]    stat_stalls;
`endif

  int n_vec;
  int n_err;
  int sc;
  int stall_sc;
  logic [TW+N-1:0] sb [$];
  logic [TW+N-1:0] mon_e;

  delay_sched #(.N(N), .DELAY(DELAY), .R(R), .TW(TW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .din_i     (din),
    .gnt_o     (gnt),
    .dl_ce_o   (dl_ce),
    .dl_d_o    (dl_d),
    .dl_q_i    (dl_q),
    .q_valid_o (q_valid),
    .q_tag_o   (q_tag),
    .q_data_o  (q_data),
    .q_ready_i (q_ready)
`ifdef DELAY_SCHED_STATS_EN
    ,
    .stat_clr_i    (stat_clr),
    .stat_grants_o (stat_grants),
    .stat_stalls_o (stat_stalls)
`endif
  );

  // Behavioural delayx: DELAY stages, advance on ce, data not reset.
  logic [N-1:0] dl_s [DELAY];
  always_ff @(posedge clk) begin
    if (dl_ce) begin
      dl_s[0] <= dl_d;
      for (int k = 1; k < DELAY; k++) dl_s[k] <= dl_s[k-1];
    end
  end
  assign dl_q = dl_s[DELAY-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] oh_idx(input logic [R-1:0] oh);
    logic [TW-1:0] r;
    r = '0;
    for (int i = 0; i < R; i++) if (oh[i]) r = TW'(i);
    return r;
  endfunction

  // One cycle: drive after the rising edge, check at the falling edge, queue granted sample.
  task automatic step(input logic [R-1:0] rq, input logic rdy, input logic [R-1:0] exp_g,
                      input logic exp_qv);
    logic [N-1:0] exp_d;
    @(posedge clk);
    #1;
    sc++;
    req     = rq;
    q_ready = rdy;
    for (int i = 0; i < R; i++) din[i*N +: N] = {sc[7:0], 4'hA, 4'(i)};
    @(negedge clk);
    exp_d = '0;
    for (int i = 0; i < R; i++) if (exp_g[i]) exp_d = din[i*N +: N];
    chk("gnt", 32'(gnt), 32'(exp_g));
    chk("dl_d", 32'(dl_d), 32'(exp_d));
    chk("q_valid", 32'(q_valid), 32'(exp_qv));
    chk("dl_ce", 32'(dl_ce), 32'(!(exp_qv && !rdy)));
    if (exp_g != '0) sb.push_back({oh_idx(exp_g), exp_d});
  endtask

  always @(negedge clk) begin
    if (rst_n && q_valid && q_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_unexpected: got tag %0d data %0h expected none", q_tag, q_data);
      end else begin
        mon_e = sb.pop_front();
        chk("out_tag", 32'(q_tag), 32'(mon_e[TW+N-1:N]));
        chk("out_data", 32'(q_data), 32'(mon_e[N-1:0]));
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    sc = 0;
    rst_n = 1'b0;
    req = '0;
    din = '0;
    q_ready = 1'b1;
`ifdef DELAY_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    #12;
    chk("rst_q_valid", 32'(q_valid), 0);
    chk("rst_q_tag", 32'(q_tag), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_dl_ce", 32'(dl_ce), 1);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Round robin from pointer 0: grants 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) step(4'hF, 1'b1, 4'(1 << (k % 4)), k >= 4);
    repeat (4) step(4'h0, 1'b1, 4'h0, 1'b1);
    step(4'h0, 1'b1, 4'h0, 1'b0);

    // Lone requester 1: output valid exactly four cycles after the grant.
    step(4'b0010, 1'b1, 4'b0010, 1'b0);
    repeat (3) step(4'h0, 1'b1, 4'h0, 1'b0);
    step(4'h0, 1'b1, 4'h0, 1'b1);
    step(4'h0, 1'b1, 4'h0, 1'b0);

    // Backpressure: pointer now 2, fill the line then refuse three cycles.
    step(4'hF, 1'b1, 4'b0100, 1'b0);
    stall_sc = sc;
    step(4'hF, 1'b1, 4'b1000, 1'b0);
    step(4'hF, 1'b1, 4'b0001, 1'b0);
    step(4'hF, 1'b1, 4'b0010, 1'b0);
    repeat (3) begin
      step(4'hF, 1'b0, 4'h0, 1'b1);
      chk("stall_tag", 32'(q_tag), 2);
      chk("stall_data", 32'(q_data), 32'({stall_sc[7:0], 8'hA2}));
    end
    step(4'hF, 1'b1, 4'b0100, 1'b1);
    repeat (4) step(4'h0, 1'b1, 4'h0, 1'b1);
    step(4'h0, 1'b1, 4'h0, 1'b0);

    // Bubbles on requester 2 (pointer 3); q_ready=0 with an empty output must not stall.
    step(4'b0100, 1'b0, 4'b0100, 1'b0);
    step(4'h0, 1'b0, 4'h0, 1'b0);
    step(4'h0, 1'b0, 4'h0, 1'b0);
    step(4'b0100, 1'b1, 4'b0100, 1'b0);
    step(4'h0, 1'b1, 4'h0, 1'b1);
    step(4'h0, 1'b0, 4'h0, 1'b0);
    step(4'h0, 1'b0, 4'h0, 1'b0);
    step(4'h0, 1'b1, 4'h0, 1'b1);
    step(4'h0, 1'b1, 4'h0, 1'b0);

    // Reset with three samples in flight (pointer 3: grants 3,0,1); they must be dropped.
    step(4'hF, 1'b1, 4'b1000, 1'b0);
    step(4'hF, 1'b1, 4'b0001, 1'b0);
    step(4'hF, 1'b1, 4'b0010, 1'b0);
    @(posedge clk);
    #1 req = '0;
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_q_valid", 32'(q_valid), 0);
    chk("mid_rst_q_tag", 32'(q_tag), 0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (DELAY + 1) step(4'h0, 1'b1, 4'h0, 1'b0);
    // Pointer back at 0, so requester 1 beats requester 3.
    step(4'b1010, 1'b1, 4'b0010, 1'b0);
    repeat (3) step(4'h0, 1'b1, 4'h0, 1'b0);
    step(4'h0, 1'b1, 4'h0, 1'b1);
    step(4'h0, 1'b1, 4'h0, 1'b0);

`ifdef DELAY_SCHED_STATS_EN
    // Pointer 2: ten grants then three stalls.
    stat_clr = 1'b1;
    step(4'h0, 1'b1, 4'h0, 1'b0);
    stat_clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(4'hF, 1'b1, 4'(1 << ((2 + k) % 4)), k >= 4);
      if (k == 0) begin
        chk("stat_grants_clr", stat_grants, 0);
        chk("stat_stalls_clr", stat_stalls, 0);
      end
    end
    repeat (3) step(4'h0, 1'b0, 4'h0, 1'b1);
    repeat (4) step(4'h0, 1'b1, 4'h0, 1'b1);
    step(4'h0, 1'b1, 4'h0, 1'b0);
    chk("stat_grants", stat_grants, 10);
    chk("stat_stalls", stat_stalls, 3);
    stat_clr = 1'b1;
    step(4'h0, 1'b1, 4'h0, 1'b0);
    stat_clr = 1'b0;
    step(4'h0, 1'b1, 4'h0, 1'b0);
    chk("stat_grants_reclr", stat_grants, 0);
    chk("stat_stalls_reclr", stat_stalls, 0);
`endif

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
